// File: rtl/hazard_pkg.sv
// Shared types and RV32I opcode constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } stage_tag_t;

    localparam stage_tag_t TAG_NONE = '0;

endpackage

// File: rtl/reg_use_dec.sv
// Opcode-only register-use decoder; validity and x0 filtering are applied by the caller.
module reg_use_dec
    import hazard_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       use_rs1,
    output logic       use_rs2,
    output logic       writes_rd,
    output logic       is_load
);

    assign use_rs1   = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign use_rs2   = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    assign writes_rd = !(opcode inside {OPC_BRANCH, OPC_STORE});
    assign is_load   = (opcode == OPC_LOAD);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble sequencing and EX-aligned forwarding selects for the 5-stage core.
// Build option: HAZARD_FORWARD_EN enables forwarding; otherwise dependents interlock until WB.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    input  logic [6:0]       id_opcode_i,
    input  logic [4:0]       id_rd_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             br_taken_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             flush_id_o,
    output logic             bubble_ex_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int RIDX_W = $clog2(NUM_REGS);

    logic dec_rs1, dec_rs2, dec_wr, dec_load;

    reg_use_dec u_dec (
        .opcode    (id_opcode_i),
        .use_rs1   (dec_rs1),
        .use_rs2   (dec_rs2),
        .writes_rd (dec_wr),
        .is_load   (dec_load)
    );

    logic       use_rs1, use_rs2;
    stage_tag_t id_tag;
    stage_tag_t ex_q, mem_q, wb_q;

    assign use_rs1 = id_valid_i && dec_rs1 && (id_rs1_i != '0);
    assign use_rs2 = id_valid_i && dec_rs2 && (id_rs2_i != '0);
    assign id_tag  = '{valid:   id_valid_i && dec_wr && (id_rd_i != '0),
                       rd:      id_rd_i,
                       is_load: id_valid_i && dec_load};

    // A tag is only valid when rd != x0, so x0 can never produce a hit here.
    function automatic logic src_hit(input stage_tag_t t, input logic [REG_W-1:0] rs,
                                     input logic used);
        return used && t.valid && (t.rd[RIDX_W-1:0] == rs[RIDX_W-1:0]);
    endfunction

    logic ex_a, ex_b, mem_a, mem_b;
    logic hz, stall;

    assign ex_a  = src_hit(ex_q,  id_rs1_i, use_rs1);
    assign ex_b  = src_hit(ex_q,  id_rs2_i, use_rs2);
    assign mem_a = src_hit(mem_q, id_rs1_i, use_rs1);
    assign mem_b = src_hit(mem_q, id_rs2_i, use_rs2);

`ifdef HAZARD_FORWARD_EN
    assign hz = ex_q.valid && ex_q.is_load && (ex_a || ex_b);
`else
    assign hz = ex_a || ex_b || mem_a || mem_b;
`endif

    // A taken branch kills the ID instruction, so its interlock is moot.
    assign stall       = hz && !br_taken_i;
    assign stall_if_o  = stall;
    assign stall_id_o  = stall;
    assign flush_id_o  = br_taken_i;
    assign bubble_ex_o = stall || br_taken_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= TAG_NONE;
            mem_q <= TAG_NONE;
            wb_q  <= TAG_NONE;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= bubble_ex_o ? TAG_NONE : id_tag;
        end
    end

`ifdef HAZARD_FORWARD_EN
    function automatic fwd_sel_e pick(input logic hit_ex, input logic hit_mem);
        if (hit_ex && !ex_q.is_load) return FWD_MEM;
        if (hit_mem)                 return FWD_WB;
        return FWD_RF;
    endfunction

    fwd_sel_e fwd_a_q, fwd_b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (bubble_ex_o) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= pick(ex_a, mem_a);
            fwd_b_q <= pick(ex_b, mem_b);
        end
    end

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;
`else
    assign fwd_a_o = FWD_RF;
    assign fwd_b_o = FWD_RF;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_o <= '0;
        else if (stall && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

    // WB is tracked for visibility only: the write-first regfile covers that distance.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{wb_q, mem_q.is_load, ex_q.is_load};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl; expectations follow the HAZARD_FORWARD_EN build setting.
module tb_hazard_ctrl;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic        br_taken;
    logic        stall_if_o, stall_id_o, flush_id_o, bubble_ex_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [31:0] stall_cnt_o;

    hazard_ctrl #(.NUM_REGS(32), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid_i  (id_valid),
        .id_opcode_i (id_opcode),
        .id_rd_i     (id_rd),
        .id_rs1_i    (id_rs1),
        .id_rs2_i    (id_rs2),
        .br_taken_i  (br_taken),
        .stall_if_o  (stall_if_o),
        .stall_id_o  (stall_id_o),
        .flush_id_o  (flush_id_o),
        .bubble_ex_o (bubble_ex_o),
        .fwd_a_o     (fwd_a_o),
        .fwd_b_o     (fwd_b_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        flush;
        logic        bubble;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          failed    = 0;
    logic [31:0] exp_cnt   = 0;

    // Drive one ID cycle, queue its expectation, then compare at the falling edge.
    task automatic run_cycle(input string name, input logic v, input logic [6:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic br, input logic e_stall,
                             input logic [1:0] e_fa, input logic [1:0] e_fb);
        exp_t e;
        id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; br_taken = br;
        e.name = name; e.stall = e_stall; e.flush = br; e.bubble = e_stall | br;
        e.fa = e_fa; e.fb = e_fb; e.cnt = exp_cnt;
        sb.push_back(e);
        if (e_stall && exp_cnt != '1) exp_cnt = exp_cnt + 1;
        @(negedge clk);
        e = sb.pop_front();
        tests_run++; if (stall_if_o !== e.stall) begin failed++;
            $display("FAIL %s stall_if: got %b want %b", e.name, stall_if_o, e.stall); end
        tests_run++; if (stall_id_o !== e.stall) begin failed++;
            $display("FAIL %s stall_id: got %b want %b", e.name, stall_id_o, e.stall); end
        tests_run++; if (flush_id_o !== e.flush) begin failed++;
            $display("FAIL %s flush_id: got %b want %b", e.name, flush_id_o, e.flush); end
        tests_run++; if (bubble_ex_o !== e.bubble) begin failed++;
            $display("FAIL %s bubble_ex: got %b want %b", e.name, bubble_ex_o, e.bubble); end
        tests_run++; if (fwd_a_o !== e.fa) begin failed++;
            $display("FAIL %s fwd_a: got %0d want %0d", e.name, fwd_a_o, e.fa); end
        tests_run++; if (fwd_b_o !== e.fb) begin failed++;
            $display("FAIL %s fwd_b: got %0d want %0d", e.name, fwd_b_o, e.fb); end
        tests_run++; if (stall_cnt_o !== e.cnt) begin failed++;
            $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt_o, e.cnt); end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0; br_taken = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        br_taken = 1'b0;
        #2;
        tests_run++;
        if ({stall_if_o, stall_id_o, flush_id_o, bubble_ex_o, fwd_a_o, fwd_b_o} !== 8'h00) begin
            failed++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {stall_if_o, stall_id_o, flush_id_o, bubble_ex_o, fwd_a_o, fwd_b_o});
        end
        tests_run++;
        if (stall_cnt_o !== 32'd0) begin
            failed++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        run_cycle("post_reset_idle", 0, OP, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fwd_ex();
        idle(3);
`ifdef HAZARD_FORWARD_EN
        run_cycle("add_x5",     1, OP, 5, 1, 2, 0, 0, 0, 0);
        run_cycle("sub_rs1_x5", 1, OP, 6, 5, 3, 0, 0, 0, 0);
        run_cycle("sub_in_ex",  0, OP, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        run_cycle("add_x5_b",   1, OP, 5, 1, 2, 0, 0, 0, 0);
        run_cycle("sub_rs2_x5", 1, OP, 6, 3, 5, 0, 0, 0, 0);
        run_cycle("sub2_in_ex", 0, OP, 0, 0, 0, 0, 0, 0, 1);
`else
        run_cycle("add_x5",     1, OP, 5, 1, 2, 0, 0, 0, 0);
        run_cycle("sub_st1",    1, OP, 6, 5, 3, 0, 1, 0, 0);
        run_cycle("sub_st2",    1, OP, 6, 5, 3, 0, 1, 0, 0);
        run_cycle("sub_issue",  1, OP, 6, 5, 3, 0, 0, 0, 0);
        run_cycle("sub_in_ex",  0, OP, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        run_cycle("add_x5_b",   1, OP, 5, 1, 2, 0, 0, 0, 0);
        run_cycle("sub2_st1",   1, OP, 6, 3, 5, 0, 1, 0, 0);
        run_cycle("sub2_st2",   1, OP, 6, 3, 5, 0, 1, 0, 0);
        run_cycle("sub2_issue", 1, OP, 6, 3, 5, 0, 0, 0, 0);
        run_cycle("sub2_in_ex", 0, OP, 0, 0, 0, 0, 0, 0, 0);
`endif
    endtask

    task automatic test_load_use();
        idle(3);
        run_cycle("lw_x5",      1, LOAD, 5, 1, 0, 0, 0, 0, 0);
        run_cycle("lu_stall",   1, OP,   6, 5, 5, 0, 1, 0, 0);
`ifdef HAZARD_FORWARD_EN
        run_cycle("lu_issue",   1, OP,   6, 5, 5, 0, 0, 0, 0);
        run_cycle("lu_in_ex",   0, OP,   0, 0, 0, 0, 0, 2, 2);
`else
        run_cycle("lu_stall2",  1, OP,   6, 5, 5, 0, 1, 0, 0);
        run_cycle("lu_issue",   1, OP,   6, 5, 5, 0, 0, 0, 0);
        run_cycle("lu_in_ex",   0, OP,   0, 0, 0, 0, 0, 0, 0);
`endif
    endtask

    task automatic test_branch_kill();
        idle(3);
        run_cycle("br_lw_x5",   1, LOAD,   5, 1, 0, 0, 0, 0, 0);
        run_cycle("br_kill_lu", 1, OP,     6, 5, 5, 1, 0, 0, 0);
        run_cycle("br_after",   0, OP,     0, 0, 0, 0, 0, 0, 0);
        run_cycle("br_plain",   1, BRANCH, 0, 1, 2, 1, 0, 0, 0);
        run_cycle("br_plain2",  0, OP,     0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_x0();
        idle(3);
        run_cycle("addi_x0",    1, OPIMM, 0, 1, 0, 0, 0, 0, 0);
        run_cycle("add_x0_x0",  1, OP,    2, 0, 0, 0, 0, 0, 0);
        run_cycle("x0_in_ex",   0, OP,    0, 0, 0, 0, 0, 0, 0);
        run_cycle("lui_x5",     1, LUI,   5, 5, 5, 0, 0, 0, 0);
        run_cycle("lui_in_ex",  0, OP,    0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_wb_distance();
        idle(3);
        run_cycle("wd_add_x5",  1, OP,    5, 1, 2, 0, 0, 0, 0);
        run_cycle("wd_addi",    1, OPIMM, 7, 8, 0, 0, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
        run_cycle("wd_sw",      1, STORE, 0, 5, 5, 0, 0, 0, 0);
        run_cycle("wd_sw_ex",   0, OP,    0, 0, 0, 0, 0, 2, 2);
`else
        run_cycle("wd_sw_st",   1, STORE, 0, 5, 5, 0, 1, 0, 0);
        run_cycle("wd_sw",      1, STORE, 0, 5, 5, 0, 0, 0, 0);
        run_cycle("wd_sw_ex",   0, OP,    0, 0, 0, 0, 0, 0, 0);
`endif
    endtask

    task automatic test_back_to_back();
        idle(3);
        run_cycle("bb_add1",    1, OP, 5, 1, 2, 0, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
        run_cycle("bb_add2",    1, OP, 5, 5, 1, 0, 0, 0, 0);
        run_cycle("bb_sub",     1, OP, 6, 5, 5, 0, 0, 1, 0);
        run_cycle("bb_sub_ex",  0, OP, 0, 0, 0, 0, 0, 1, 1);
`else
        run_cycle("bb_add2_s1", 1, OP, 5, 5, 1, 0, 1, 0, 0);
        run_cycle("bb_add2_s2", 1, OP, 5, 5, 1, 0, 1, 0, 0);
        run_cycle("bb_add2",    1, OP, 5, 5, 1, 0, 0, 0, 0);
        run_cycle("bb_sub_s1",  1, OP, 6, 5, 5, 0, 1, 0, 0);
        run_cycle("bb_sub_s2",  1, OP, 6, 5, 5, 0, 1, 0, 0);
        run_cycle("bb_sub",     1, OP, 6, 5, 5, 0, 0, 0, 0);
        run_cycle("bb_sub_ex",  0, OP, 0, 0, 0, 0, 0, 0, 0);
`endif
    endtask

    task automatic test_reset_mid_stall();
        idle(3);
        run_cycle("rm_lw_x5", 1, LOAD, 5, 1, 0, 0, 0, 0, 0);
        id_valid = 1'b1; id_opcode = OP; id_rd = 5'd6; id_rs1 = 5'd5; id_rs2 = 5'd5;
        br_taken = 1'b0;
        @(negedge clk);
        tests_run++;
        if (stall_if_o !== 1'b1) begin
            failed++; $display("FAIL rm_pre_stall: got %b want 1", stall_if_o);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if ({stall_if_o, stall_id_o, flush_id_o, bubble_ex_o, fwd_a_o, fwd_b_o} !== 8'h00) begin
            failed++;
            $display("FAIL rm_async_ctrl: got %b want 00000000",
                     {stall_if_o, stall_id_o, flush_id_o, bubble_ex_o, fwd_a_o, fwd_b_o});
        end
        tests_run++;
        if (stall_cnt_o !== 32'd0) begin
            failed++; $display("FAIL rm_async_cnt: got %0d want 0", stall_cnt_o);
        end
        exp_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_cycle("rm_first_issue", 1, OP, 6, 5, 5, 0, 0, 0, 0);
        run_cycle("rm_first_ex",    0, OP, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_branch_kill();
        test_x0();
        test_wb_distance();
        test_back_to_back();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
